// File: rtl/core_pwr_pkg.sv
// Shared types for the core power sequencer: state encoding, output bundle
// and the per-state output decode.
package core_pwr_pkg;

   typedef enum logic [3:0] {
      OFF     = 4'd0,
      PWR_ON  = 4'd1,
      RESTORE = 4'd2,
      ISO_OFF = 4'd3,
      CLK_ON  = 4'd4,
      RST_REL = 4'd5,
      ON      = 4'd6,
      DRAIN   = 4'd7,
      CLK_OFF = 4'd8,
      ISO_ON  = 4'd9,
      SAVE    = 4'd10,
      PWR_OFF = 4'd11
   } core_pwr_state_e;

   typedef struct packed {
      logic power_en;
      logic isolate;
      logic retain;
      logic clk_en;
      logic core_rst_n;
      logic on_ack;
      logic busy;
   } core_pwr_out_t;

   localparam core_pwr_out_t PWR_OUT_RST = 7'b0100000;

   function automatic logic is_timed(input core_pwr_state_e s);
      return !(s inside {OFF, ON, DRAIN});
   endfunction

   // Field order: power_en, isolate, retain, clk_en, core_rst_n, on_ack, busy.
   function automatic core_pwr_out_t pwr_decode(input core_pwr_state_e s, input logic ret_q);
      core_pwr_out_t o;
      o = PWR_OUT_RST;
      case (s)
         OFF:     o = {1'b0, 1'b1, ret_q, 1'b0, 1'b0, 1'b0, 1'b0};
         PWR_ON:  o = {1'b1, 1'b1, ret_q, 1'b0, 1'b0, 1'b0, 1'b1};
         RESTORE: o = {1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1};
         ISO_OFF: o = {1'b1, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1};
         CLK_ON:  o = {1'b1, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1};
         RST_REL: o = {1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1};
         ON:      o = {1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b0};
         DRAIN:   o = {1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b1};
         CLK_OFF: o = {1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b1};
         ISO_ON:  o = {1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1};
         SAVE:    o = {1'b1, 1'b1, ret_q, 1'b0, 1'b0, 1'b0, 1'b1};
         PWR_OFF: o = {1'b0, 1'b1, ret_q, 1'b0, 1'b0, 1'b0, 1'b1};
         default: o = PWR_OUT_RST;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/core_power_seq_if.sv
// Request/acknowledge and power-control bundle between the SoC power manager,
// the core socket and the sequencer.
interface core_power_seq_if;
   import core_pwr_pkg::*;

   logic            on_req;
   logic            ret_en;
   logic            core_idle;
   logic            power_en;
   logic            isolate;
   logic            retain;
   logic            clk_en;
   logic            core_rst_n;
   logic            on_ack;
   logic            busy;
   core_pwr_state_e state_o;

   modport master (
      output on_req, ret_en, core_idle,
      input  power_en, isolate, retain, clk_en, core_rst_n, on_ack, busy, state_o
   );

   modport slave (
      input  on_req, ret_en, core_idle,
      output power_en, isolate, retain, clk_en, core_rst_n, on_ack, busy, state_o
   );

endinterface

// File: rtl/core_pwr_dwell_cnt.sv
// Down-counter shared by every timed sequencing state; saturates at zero.
module core_pwr_dwell_cnt #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_p0 <= '0;
      end else if (load) begin
         cnt_p0 <= load_val;
      end else if (cnt_p0 != '0) begin
         cnt_p0 <= cnt_p0 - 1'b1;
      end
   end

   assign zero = (cnt_p0 == '0);

endmodule

// File: rtl/core_power_seq.sv
// Per-core power sequencer: walks timed power-up / power-down sequences on a
// level request and drives registered power-control outputs.
module core_power_seq
   import core_pwr_pkg::*;
#(
   parameter int T_PWR_UP = 16,
   parameter int T_PWR_DN = 8,
   parameter int T_STEP   = 2
) (
   input  logic            clk,
   input  logic            rst,
   core_power_seq_if.slave bus
);

   localparam int T_MAX = (T_PWR_UP > T_PWR_DN) ?
                          ((T_PWR_UP > T_STEP) ? T_PWR_UP : T_STEP) :
                          ((T_PWR_DN > T_STEP) ? T_PWR_DN : T_STEP);
   localparam int CNT_W = $clog2(T_MAX + 1);

   core_pwr_state_e  state_p0, state_d;
   core_pwr_out_t    out_d, out_p1;
   logic             ret_q;
   logic             cnt_load, cnt_zero;
   logic [CNT_W-1:0] cnt_val;

   core_pwr_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= OFF;
      end else begin
         state_p0 <= state_d;
      end
   end

   always_comb begin
      state_d = state_p0;
      case (state_p0)
         OFF:     if (bus.on_req) state_d = PWR_ON;
         PWR_ON:  if (cnt_zero) state_d = RESTORE;
         RESTORE: if (cnt_zero) state_d = ISO_OFF;
         ISO_OFF: if (cnt_zero) state_d = CLK_ON;
         CLK_ON:  if (cnt_zero) state_d = RST_REL;
         RST_REL: if (cnt_zero) state_d = ON;
         ON:      if (!bus.on_req) state_d = DRAIN;
         // A returning request wins: nothing has been switched yet in DRAIN.
         DRAIN: begin
            if (bus.on_req)         state_d = ON;
            else if (bus.core_idle) state_d = CLK_OFF;
         end
         CLK_OFF: if (cnt_zero) state_d = ISO_ON;
         ISO_ON:  if (cnt_zero) state_d = SAVE;
         SAVE:    if (cnt_zero) state_d = PWR_OFF;
         PWR_OFF: if (cnt_zero) state_d = OFF;
         default: state_d = OFF;
      endcase
   end

   always_comb begin
      cnt_load = (state_d != state_p0) && is_timed(state_d);
      case (state_d)
         PWR_ON:  cnt_val = CNT_W'(T_PWR_UP - 1);
         PWR_OFF: cnt_val = CNT_W'(T_PWR_DN - 1);
         default: cnt_val = CNT_W'(T_STEP - 1);
      endcase
      out_d = pwr_decode(state_p0, ret_q);
   end

   // Output register stage: outputs trail the state register by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_p1 <= PWR_OUT_RST;
         ret_q  <= 1'b0;
      end else begin
         out_p1 <= out_d;
         if (state_p0 == DRAIN && state_d == CLK_OFF) begin
            ret_q <= bus.ret_en;
         end else if (state_p0 == RESTORE) begin
            ret_q <= 1'b0;
         end
      end
   end

   assign bus.power_en   = out_p1.power_en;
   assign bus.isolate    = out_p1.isolate;
   assign bus.retain     = out_p1.retain;
   assign bus.clk_en     = out_p1.clk_en;
   assign bus.core_rst_n = out_p1.core_rst_n;
   assign bus.on_ack     = out_p1.on_ack;
   assign bus.busy       = out_p1.busy;
   assign bus.state_o    = state_p0;

endmodule

// File: tb/tb_core_power_seq.sv
// Directed bench for core_power_seq at default timing (16/8/2).
module tb_core_power_seq;
   import core_pwr_pkg::*;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   core_power_seq_if bus();

   core_power_seq #(.T_PWR_UP(16), .T_PWR_DN(8), .T_STEP(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      bus.on_req = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.power_en !== 1'b0) begin failures++; $display("FAIL rst_power_en got=%0b exp=0", bus.power_en); end
      checks++; if (bus.isolate !== 1'b1) begin failures++; $display("FAIL rst_isolate got=%0b exp=1", bus.isolate); end
      checks++; if (bus.retain !== 1'b0) begin failures++; $display("FAIL rst_retain got=%0b exp=0", bus.retain); end
      checks++; if (bus.clk_en !== 1'b0) begin failures++; $display("FAIL rst_clk_en got=%0b exp=0", bus.clk_en); end
      checks++; if (bus.core_rst_n !== 1'b0) begin failures++; $display("FAIL rst_core_rst_n got=%0b exp=0", bus.core_rst_n); end
      checks++; if (bus.on_ack !== 1'b0) begin failures++; $display("FAIL rst_on_ack got=%0b exp=0", bus.on_ack); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.state_o !== OFF) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", bus.state_o, OFF); end
      bus.on_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.state_o !== OFF) begin failures++; $display("FAIL rst_idle_state got=%0d exp=%0d", bus.state_o, OFF); end
   endtask

   task automatic test_power_up();
      int t_pwr = -1, t_iso = -1, t_clk = -1, t_rst = -1, t_ack = -1;
      bus.on_req = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 0) begin
            checks++; if (bus.state_o !== PWR_ON) begin failures++; $display("FAIL up_state0 got=%0d exp=%0d", bus.state_o, PWR_ON); end
         end
         if (t_pwr < 0 && bus.power_en === 1'b1) t_pwr = i;
         if (t_iso < 0 && bus.isolate === 1'b0) t_iso = i;
         if (t_clk < 0 && bus.clk_en === 1'b1) t_clk = i;
         if (t_rst < 0 && bus.core_rst_n === 1'b1) t_rst = i;
         if (t_ack < 0 && bus.on_ack === 1'b1) t_ack = i;
      end
      checks++; if (t_pwr != 1) begin failures++; $display("FAIL up_power_en_rise got=%0d exp=1", t_pwr); end
      checks++; if (t_iso != 19) begin failures++; $display("FAIL up_isolate_fall got=%0d exp=19", t_iso); end
      checks++; if (t_clk != 21) begin failures++; $display("FAIL up_clk_en_rise got=%0d exp=21", t_clk); end
      checks++; if (t_rst != 23) begin failures++; $display("FAIL up_core_rst_n_rise got=%0d exp=23", t_rst); end
      checks++; if (t_ack != 25) begin failures++; $display("FAIL up_on_ack_rise got=%0d exp=25", t_ack); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL up_busy_end got=%0b exp=0", bus.busy); end
      checks++; if (bus.state_o !== ON) begin failures++; $display("FAIL up_state_end got=%0d exp=%0d", bus.state_o, ON); end
   endtask

   task automatic test_power_down();
      int t_ack = -1, t_clk = -1, t_iso = -1, t_pwr = -1, t_off = -1, t_bsr = -1, t_bsf = -1, ret_hi = 0;
      bus.on_req = 1'b0; bus.ret_en = 1'b0; bus.core_idle = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (t_ack < 0 && bus.on_ack === 1'b0) t_ack = i;
         if (t_clk < 0 && bus.clk_en === 1'b0) t_clk = i;
         if (t_iso < 0 && bus.isolate === 1'b1) t_iso = i;
         if (t_pwr < 0 && bus.power_en === 1'b0) t_pwr = i;
         if (t_off < 0 && bus.state_o === OFF) t_off = i;
         if (t_bsr < 0 && bus.busy === 1'b1) t_bsr = i;
         if (t_bsr >= 0 && t_bsf < 0 && bus.busy === 1'b0) t_bsf = i;
         if (bus.retain !== 1'b0) ret_hi++;
      end
      checks++; if (t_ack != 1) begin failures++; $display("FAIL dn_on_ack_fall got=%0d exp=1", t_ack); end
      checks++; if (t_clk != 2) begin failures++; $display("FAIL dn_clk_en_fall got=%0d exp=2", t_clk); end
      checks++; if (t_iso != 4) begin failures++; $display("FAIL dn_isolate_rise got=%0d exp=4", t_iso); end
      checks++; if (t_pwr != 8) begin failures++; $display("FAIL dn_power_en_fall got=%0d exp=8", t_pwr); end
      checks++; if (t_off != 15) begin failures++; $display("FAIL dn_state_off got=%0d exp=15", t_off); end
      checks++; if (t_bsf != 16) begin failures++; $display("FAIL dn_busy_fall got=%0d exp=16", t_bsf); end
      checks++; if (ret_hi != 0) begin failures++; $display("FAIL dn_retain_cycles got=%0d exp=0", ret_hi); end
      checks++; if (bus.core_rst_n !== 1'b0) begin failures++; $display("FAIL dn_core_rst_n got=%0b exp=0", bus.core_rst_n); end
   endtask

   task automatic bring_up();
      bus.on_req = 1'b1;
      repeat (30) @(negedge clk);
   endtask

   task automatic test_drain_abort();
      int toggles = 0;
      bus.on_req = 1'b0; bus.core_idle = 1'b0; bus.ret_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.clk_en !== 1'b1 || bus.isolate !== 1'b0 || bus.power_en !== 1'b1) toggles++;
      end
      checks++; if (bus.state_o !== DRAIN) begin failures++; $display("FAIL drain_state got=%0d exp=%0d", bus.state_o, DRAIN); end
      checks++; if (bus.on_ack !== 1'b0) begin failures++; $display("FAIL drain_on_ack got=%0b exp=0", bus.on_ack); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL drain_busy got=%0b exp=1", bus.busy); end
      bus.on_req = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         if (bus.clk_en !== 1'b1 || bus.isolate !== 1'b0 || bus.power_en !== 1'b1) toggles++;
         if (j == 0) begin
            checks++; if (bus.state_o !== ON) begin failures++; $display("FAIL drain_back_state got=%0d exp=%0d", bus.state_o, ON); end
         end
      end
      checks++; if (bus.on_ack !== 1'b1) begin failures++; $display("FAIL drain_back_on_ack got=%0b exp=1", bus.on_ack); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL drain_back_busy got=%0b exp=0", bus.busy); end
      checks++; if (toggles != 0) begin failures++; $display("FAIL drain_ctrl_toggles got=%0d exp=0", toggles); end
      bus.core_idle = 1'b1;
   endtask

   task automatic test_retention();
      int t_ret = -1, t_pwr = -1, t_rf = -1;
      bus.on_req = 1'b0; bus.ret_en = 1'b1; bus.core_idle = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 10) bus.ret_en = 1'b0;
         if (t_ret < 0 && bus.retain === 1'b1) t_ret = i;
      end
      checks++; if (t_ret != 6) begin failures++; $display("FAIL ret_retain_rise got=%0d exp=6", t_ret); end
      checks++; if (bus.retain !== 1'b1) begin failures++; $display("FAIL ret_retain_off got=%0b exp=1", bus.retain); end
      checks++; if (bus.state_o !== OFF) begin failures++; $display("FAIL ret_state_off got=%0d exp=%0d", bus.state_o, OFF); end
      bus.on_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (t_pwr < 0 && bus.power_en === 1'b1) t_pwr = i;
         if (t_rf < 0 && bus.retain === 1'b0) t_rf = i;
      end
      checks++; if (t_pwr != 1) begin failures++; $display("FAIL ret_power_en_rise got=%0d exp=1", t_pwr); end
      checks++; if (t_rf != 17) begin failures++; $display("FAIL ret_retain_fall got=%0d exp=17", t_rf); end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_req_toggle();
      int t_ack = -1, ack_cnt = 0;
      bus.on_req = 1'b0; bus.ret_en = 1'b0; bus.core_idle = 1'b1;
      repeat (20) @(negedge clk);
      bus.on_req = 1'b1;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (i == 3) bus.on_req = 1'b0;
         if (i == 6) begin
            bus.on_req = 1'b1;
            checks++; if (bus.state_o !== PWR_ON) begin failures++; $display("FAIL tog_mid_state got=%0d exp=%0d", bus.state_o, PWR_ON); end
         end
         if (i == 20) bus.on_req = 1'b0;
         if (bus.on_ack === 1'b1) begin
            ack_cnt++;
            if (t_ack < 0) t_ack = i;
         end
      end
      checks++; if (t_ack != 25) begin failures++; $display("FAIL tog_on_ack_rise got=%0d exp=25", t_ack); end
      checks++; if (ack_cnt != 1) begin failures++; $display("FAIL tog_on_ack_cycles got=%0d exp=1", ack_cnt); end
      checks++; if (bus.state_o !== OFF) begin failures++; $display("FAIL tog_state_end got=%0d exp=%0d", bus.state_o, OFF); end
      checks++; if (bus.power_en !== 1'b0) begin failures++; $display("FAIL tog_power_en_end got=%0b exp=0", bus.power_en); end
   endtask

   task automatic test_reset_mid();
      bus.on_req = 1'b1;
      for (int i = 0; i <= 20; i++) @(negedge clk);
      checks++; if (bus.state_o !== CLK_ON) begin failures++; $display("FAIL rmid_pre_state got=%0d exp=%0d", bus.state_o, CLK_ON); end
      checks++; if (bus.isolate !== 1'b0) begin failures++; $display("FAIL rmid_pre_isolate got=%0b exp=0", bus.isolate); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.state_o !== OFF) begin failures++; $display("FAIL rmid_state got=%0d exp=%0d", bus.state_o, OFF); end
      checks++; if (bus.power_en !== 1'b0) begin failures++; $display("FAIL rmid_power_en got=%0b exp=0", bus.power_en); end
      checks++; if (bus.isolate !== 1'b1) begin failures++; $display("FAIL rmid_isolate got=%0b exp=1", bus.isolate); end
      checks++; if (bus.retain !== 1'b0) begin failures++; $display("FAIL rmid_retain got=%0b exp=0", bus.retain); end
      checks++; if (bus.clk_en !== 1'b0) begin failures++; $display("FAIL rmid_clk_en got=%0b exp=0", bus.clk_en); end
      checks++; if (bus.core_rst_n !== 1'b0) begin failures++; $display("FAIL rmid_core_rst_n got=%0b exp=0", bus.core_rst_n); end
      checks++; if (bus.on_ack !== 1'b0) begin failures++; $display("FAIL rmid_on_ack got=%0b exp=0", bus.on_ack); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", bus.busy); end
      rst = 1'b0;
      bus.on_req = 1'b0;
      @(negedge clk);
      checks++; if (bus.state_o !== OFF) begin failures++; $display("FAIL rmid_after_state got=%0d exp=%0d", bus.state_o, OFF); end
   endtask

   initial begin
      rst           = 1'b1;
      bus.on_req    = 1'b0;
      bus.ret_en    = 1'b0;
      bus.core_idle = 1'b1;
      test_reset();
      test_power_up();
      test_power_down();
      bring_up();
      test_drain_abort();
      test_retention();
      test_req_toggle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
